// File: rtl/calc_rx_pkg.sv
// calc_rx_pkg: shared constants and state encoding
// for the BINARY_CALC serial frame receiver.
package calc_rx_pkg;

    localparam int FRAME_W  = 32;
    localparam int CNT_W    = 6;
    localparam int A_MSB    = 31;
    localparam int B_MSB    = 23;
    localparam int ALU_MSB  = 15;
    localparam int SEL_MSB  = 7;
    localparam int FLAG_MSB = 3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_e;

endpackage

// File: rtl/calc_frame_receiver_edge.sv
// calc_edge_detect: turns the divided bit clock
// into a one-CLK rising-edge strobe.
module calc_edge_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic CLK_Tx,
    output logic BIT_STB
);

    logic clk_tx_q;
    logic clk_tx_d;

    assign clk_tx_d = CLK_Tx;

    // Remember last CLK_Tx level to find its rising edge
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            clk_tx_q <= 1'b0;
        end else begin
            clk_tx_q <= clk_tx_d;
        end
    end

    assign BIT_STB = CLK_Tx & ~clk_tx_q;

endmodule

// File: rtl/calc_frame_receiver.sv
// calc_frame_receiver: deserialises 32-bit MSB-first frames into a
// VALID/READY output register. Option: CALC_RX_FRAME_CNT_EN adds RX_FRAME_CNT.
module calc_frame_receiver
    import calc_rx_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SIN,
    input  logic        SIN_VALID,
    input  logic        CLK_Tx,
    input  logic        FRAME_READY,
    output logic        FRAME_VALID,
    output logic [31:0] FRAME_DATA,
    output logic [7:0]  RX_A,
    output logic [7:0]  RX_B,
    output logic [7:0]  RX_ALU_OUT,
    output logic [3:0]  RX_SEL,
    output logic [3:0]  RX_FLAG,
    output logic        FRAME_ERR,
    output logic        OVERRUN
`ifdef CALC_RX_FRAME_CNT_EN
    ,
    output logic [15:0] RX_FRAME_CNT
`endif
);

    rx_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [FRAME_W-1:0] shift_q;
    logic [FRAME_W-1:0] shift_d;
    logic [FRAME_W-1:0] data_q;
    logic               valid_q;
    logic               err_q;
    logic               ovr_q;
    logic               bit_stb;
`ifdef CALC_RX_FRAME_CNT_EN
    logic [15:0]        fcnt_q;
`endif

    calc_edge_detect u_edge (
        .CLK     (CLK),
        .RESET   (RESET),
        .CLK_Tx  (CLK_Tx),
        .BIT_STB (bit_stb)
    );

    assign shift_d = {shift_q[FRAME_W-2:0], SIN};
    assign cnt_d   = cnt_q + CNT_ONE;

    // Receive FSM with bit counter, shift reg, output register and flags
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef CALC_RX_FRAME_CNT_EN
            fcnt_q  <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            if (valid_q && FRAME_READY) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (bit_stb && SIN_VALID) begin
                        shift_q <= shift_d;
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!SIN_VALID) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        shift_q <= '0;
                        state_q <= ST_IDLE;
                    end else if (bit_stb) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_d;
                        if (cnt_d == CNT_FULL) begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    // A load wins over a same-cycle handshake clear
                    if (!valid_q || FRAME_READY) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
`ifdef CALC_RX_FRAME_CNT_EN
                        fcnt_q  <= fcnt_q + 16'd1;
`endif
                    end else begin
                        ovr_q <= 1'b1;
                    end
                    cnt_q   <= '0;
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!SIN_VALID) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign FRAME_VALID = valid_q;
    assign FRAME_DATA  = data_q;
    assign FRAME_ERR   = err_q;
    assign OVERRUN     = ovr_q;
    assign RX_A        = data_q[A_MSB -: 8];
    assign RX_B        = data_q[B_MSB -: 8];
    assign RX_ALU_OUT  = data_q[ALU_MSB -: 8];
    assign RX_SEL      = data_q[SEL_MSB -: 4];
    assign RX_FLAG     = data_q[FLAG_MSB -: 4];
`ifdef CALC_RX_FRAME_CNT_EN
    assign RX_FRAME_CNT = fcnt_q;
`endif

endmodule

// File: tb/tb_calc_frame_receiver.sv
// tb_calc_frame_receiver: directed scenarios for calc_frame_receiver.
// Optional block checked when CALC_RX_FRAME_CNT_EN is defined.
module tb_calc_frame_receiver;

    logic        CLK;
    logic        RESET;
    logic        SIN;
    logic        SIN_VALID;
    logic        CLK_Tx;
    logic        FRAME_READY;
    logic        FRAME_VALID;
    logic [31:0] FRAME_DATA;
    logic [7:0]  RX_A;
    logic [7:0]  RX_B;
    logic [7:0]  RX_ALU_OUT;
    logic [3:0]  RX_SEL;
    logic [3:0]  RX_FLAG;
    logic        FRAME_ERR;
    logic        OVERRUN;
`ifdef CALC_RX_FRAME_CNT_EN
    logic [15:0] RX_FRAME_CNT;
`endif

    int total;
    int bad;
    int vcyc;
    int ecyc;
    logic [31:0] seen_data;
    logic [7:0]  seen_a;
    logic [7:0]  seen_b;
    logic [7:0]  seen_alu;
    logic [3:0]  seen_sel;
    logic [3:0]  seen_flag;

    calc_frame_receiver dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SIN         (SIN),
        .SIN_VALID   (SIN_VALID),
        .CLK_Tx      (CLK_Tx),
        .FRAME_READY (FRAME_READY),
        .FRAME_VALID (FRAME_VALID),
        .FRAME_DATA  (FRAME_DATA),
        .RX_A        (RX_A),
        .RX_B        (RX_B),
        .RX_ALU_OUT  (RX_ALU_OUT),
        .RX_SEL      (RX_SEL),
        .RX_FLAG     (RX_FLAG),
        .FRAME_ERR   (FRAME_ERR),
        .OVERRUN     (OVERRUN)
`ifdef CALC_RX_FRAME_CNT_EN
        ,
        .RX_FRAME_CNT(RX_FRAME_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Observe outputs mid-cycle: count VALID and ERR cycles, keep last frame
    always @(negedge CLK) begin
        if (FRAME_VALID) begin
            vcyc      = vcyc + 1;
            seen_data = FRAME_DATA;
            seen_a    = RX_A;
            seen_b    = RX_B;
            seen_alu  = RX_ALU_OUT;
            seen_sel  = RX_SEL;
            seen_flag = RX_FLAG;
        end
        if (FRAME_ERR) begin
            ecyc = ecyc + 1;
        end
    end

    task automatic clear_obs();
        vcyc      = 0;
        ecyc      = 0;
        seen_data = '0;
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo,
                            input bit glitch);
        SIN    = b;
        CLK_Tx = 1'b1;
        for (int i = 0; i < hi; i++) begin
            @(negedge CLK);
            if (glitch && (i < hi - 1)) SIN = ~SIN;
        end
        CLK_Tx = 1'b0;
        repeat (lo) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [63:0] bits, input int n,
                              input int hi, input int lo, input bit glitch);
        @(negedge CLK);
        SIN_VALID = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_bit(bits[63-i], hi, lo, glitch);
        end
        SIN_VALID = 1'b0;
        SIN       = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET     = 1'b0;
        SIN_VALID = 1'b0;
        CLK_Tx    = 1'b0;
        SIN       = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET       = 1'b0;
        SIN         = 1'b0;
        SIN_VALID   = 1'b0;
        CLK_Tx      = 1'b0;
        FRAME_READY = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if (FRAME_VALID !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%0b exp=0", FRAME_VALID);
        end
        total++;
        if (FRAME_DATA !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", FRAME_DATA);
        end
        total++;
        if (FRAME_ERR !== 1'b0) begin
            bad++; $display("FAIL reset_err got=%0b exp=0", FRAME_ERR);
        end
        total++;
        if (OVERRUN !== 1'b0) begin
            bad++; $display("FAIL reset_ovr got=%0b exp=0", OVERRUN);
        end
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        clear_obs();
    endtask

    task automatic test_basic();
        FRAME_READY = 1'b1;
        clear_obs();
        send_frame({32'hA53C_7E91, 32'h0}, 32, 1, 1, 1'b0);
        total++;
        if (vcyc !== 1) begin
            bad++; $display("FAIL basic_pulse got=%0d exp=1", vcyc);
        end
        total++;
        if (seen_data !== 32'hA53C_7E91) begin
            bad++; $display("FAIL basic_data got=%h exp=a53c7e91", seen_data);
        end
        total++;
        if (seen_a !== 8'hA5 || seen_b !== 8'h3C) begin
            bad++; $display("FAIL basic_ab got=%h/%h exp=a5/3c", seen_a, seen_b);
        end
        total++;
        if (seen_alu !== 8'h7E) begin
            bad++; $display("FAIL basic_alu got=%h exp=7e", seen_alu);
        end
        total++;
        if (seen_sel !== 4'h9 || seen_flag !== 4'h1) begin
            bad++; $display("FAIL basic_selflag got=%h/%h exp=9/1",
                            seen_sel, seen_flag);
        end
        total++;
        if (FRAME_VALID !== 1'b0 || ecyc !== 0) begin
            bad++; $display("FAIL basic_idle got=%0b/%0d exp=0/0",
                            FRAME_VALID, ecyc);
        end
    endtask

    task automatic test_truncated();
        FRAME_READY = 1'b1;
        clear_obs();
        send_frame({32'hFFFF_FFFF, 32'h0}, 17, 1, 1, 1'b0);
        total++;
        if (ecyc !== 1) begin
            bad++; $display("FAIL trunc_err_cycles got=%0d exp=1", ecyc);
        end
        total++;
        if (vcyc !== 0) begin
            bad++; $display("FAIL trunc_valid got=%0d exp=0", vcyc);
        end
        clear_obs();
        send_frame({32'h0000_0001, 32'h0}, 32, 1, 1, 1'b0);
        total++;
        if (vcyc !== 1 || seen_data !== 32'h0000_0001) begin
            bad++; $display("FAIL trunc_next got=%0d/%h exp=1/00000001",
                            vcyc, seen_data);
        end
        total++;
        if (ecyc !== 0) begin
            bad++; $display("FAIL trunc_next_err got=%0d exp=0", ecyc);
        end
    endtask

    task automatic test_overrun();
        FRAME_READY = 1'b0;
        clear_obs();
        send_frame({32'h1111_1111, 32'h0}, 32, 1, 1, 1'b0);
        total++;
        if (FRAME_VALID !== 1'b1 || FRAME_DATA !== 32'h1111_1111) begin
            bad++; $display("FAIL ovr_hold1 got=%0b/%h exp=1/11111111",
                            FRAME_VALID, FRAME_DATA);
        end
        total++;
        if (OVERRUN !== 1'b0) begin
            bad++; $display("FAIL ovr_early got=%0b exp=0", OVERRUN);
        end
        send_frame({32'h2222_2222, 32'h0}, 32, 1, 1, 1'b0);
        total++;
        if (FRAME_DATA !== 32'h1111_1111) begin
            bad++; $display("FAIL ovr_keep got=%h exp=11111111", FRAME_DATA);
        end
        total++;
        if (OVERRUN !== 1'b1 || FRAME_VALID !== 1'b1) begin
            bad++; $display("FAIL ovr_flag got=%0b/%0b exp=1/1",
                            OVERRUN, FRAME_VALID);
        end
        FRAME_READY = 1'b1;
        @(negedge CLK);
        total++;
        if (FRAME_VALID !== 1'b0) begin
            bad++; $display("FAIL ovr_accept got=%0b exp=0", FRAME_VALID);
        end
        repeat (3) @(negedge CLK);
        total++;
        if (OVERRUN !== 1'b1) begin
            bad++; $display("FAIL ovr_sticky got=%0b exp=1", OVERRUN);
        end
    endtask

    task automatic test_reset_mid();
        FRAME_READY = 1'b0;
        @(negedge CLK);
        SIN_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1, 1, 1, 1'b0);
        end
        RESET = 1'b0;
        #1;
        total++;
        if (OVERRUN !== 1'b0 || FRAME_ERR !== 1'b0) begin
            bad++; $display("FAIL rstmid_flags got=%0b/%0b exp=0/0",
                            OVERRUN, FRAME_ERR);
        end
        total++;
        if (FRAME_VALID !== 1'b0 || FRAME_DATA !== 32'h0) begin
            bad++; $display("FAIL rstmid_out got=%0b/%h exp=0/0",
                            FRAME_VALID, FRAME_DATA);
        end
        @(negedge CLK);
        SIN_VALID = 1'b0;
        CLK_Tx    = 1'b0;
        @(negedge CLK);
        RESET       = 1'b1;
        FRAME_READY = 1'b1;
        repeat (2) @(negedge CLK);
        clear_obs();
        send_frame({32'hDEAD_BEEF, 32'h0}, 32, 1, 1, 1'b0);
        total++;
        if (vcyc !== 1 || seen_data !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rstmid_frame got=%0d/%h exp=1/deadbeef",
                            vcyc, seen_data);
        end
        total++;
        if (OVERRUN !== 1'b0 || ecyc !== 0) begin
            bad++; $display("FAIL rstmid_clean got=%0b/%0d exp=0/0",
                            OVERRUN, ecyc);
        end
    endtask

    task automatic test_slow_and_long();
        FRAME_READY = 1'b1;
        clear_obs();
        send_frame({32'hC3A5_0F96, 32'h0}, 32, 5, 2, 1'b1);
        total++;
        if (vcyc !== 1 || seen_data !== 32'hC3A5_0F96) begin
            bad++; $display("FAIL slow_frame got=%0d/%h exp=1/c3a50f96",
                            vcyc, seen_data);
        end
        total++;
        if (ecyc !== 0) begin
            bad++; $display("FAIL slow_err got=%0d exp=0", ecyc);
        end
        clear_obs();
        send_frame({32'h1234_5678, 8'hFF, 24'h0}, 40, 1, 1, 1'b0);
        total++;
        if (vcyc !== 1 || seen_data !== 32'h1234_5678) begin
            bad++; $display("FAIL long_frame got=%0d/%h exp=1/12345678",
                            vcyc, seen_data);
        end
        total++;
        if (ecyc !== 0 || OVERRUN !== 1'b0) begin
            bad++; $display("FAIL long_flags got=%0d/%0b exp=0/0",
                            ecyc, OVERRUN);
        end
    endtask

`ifdef CALC_RX_FRAME_CNT_EN
    task automatic test_frame_cnt();
        do_reset();
        total++;
        if (RX_FRAME_CNT !== 16'd0) begin
            bad++; $display("FAIL cnt_reset got=%0d exp=0", RX_FRAME_CNT);
        end
        FRAME_READY = 1'b1;
        send_frame({32'h0102_0304, 32'h0}, 32, 1, 1, 1'b0);
        send_frame({32'h0506_0708, 32'h0}, 32, 1, 1, 1'b0);
        send_frame({32'hFFFF_FFFF, 32'h0}, 17, 1, 1, 1'b0);
        FRAME_READY = 1'b0;
        send_frame({32'h0A0B_0C0D, 32'h0}, 32, 1, 1, 1'b0);
        send_frame({32'h0E0F_1011, 32'h0}, 32, 1, 1, 1'b0);
        total++;
        if (RX_FRAME_CNT !== 16'd3) begin
            bad++; $display("FAIL cnt_value got=%0d exp=3", RX_FRAME_CNT);
        end
        total++;
        if (OVERRUN !== 1'b1 || FRAME_DATA !== 32'h0A0B_0C0D) begin
            bad++; $display("FAIL cnt_ovr got=%0b/%h exp=1/0a0b0c0d",
                            OVERRUN, FRAME_DATA);
        end
        FRAME_READY = 1'b1;
        repeat (2) @(negedge CLK);
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        clear_obs();
        test_reset();
        test_basic();
        test_truncated();
        test_overrun();
        test_reset_mid();
        test_slow_and_long();
`ifdef CALC_RX_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
